// File: rtl/lock_arbiter.sv
// lock_arbiter: hardware lock table serving LOCK/UNLOCK commands from accelerators, one command in flight.
// Ports: clk/rst (sync, active-high); cmd_tvalid/cmd_tready/cmd_tdata/cmd_tid command stream
// (code in [7:0], lock ID at [8 +: LOCK_ID_BITS]); ack_tvalid/ack_tready/ack_tdata/ack_tdest
// acknowledge stream (0x01 grant, 0x00 reject, LOCK only); locks_held count; err_cnt saturating
// illegal-command count. Define LOCK_OWNER_CHECK_EN to restrict UNLOCK to the recorded owner.
module lock_arbiter #(
  parameter int NUM_LOCKS = 256,
  parameter int ACC_ID_BITS = 8,
  localparam int LOCK_ID_BITS = $clog2(NUM_LOCKS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_tvalid,
  output logic                   cmd_tready,
  input  logic [63:0]            cmd_tdata,
  input  logic [ACC_ID_BITS-1:0] cmd_tid,
  output logic                   ack_tvalid,
  input  logic                   ack_tready,
  output logic [7:0]             ack_tdata,
  output logic [ACC_ID_BITS-1:0] ack_tdest,
  output logic [LOCK_ID_BITS:0]  locks_held,
  output logic [15:0]            err_cnt
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q;
  logic [7:0] code_q;
  logic [LOCK_ID_BITS-1:0] lid_q;
  logic [ACC_ID_BITS-1:0] aid_q;
  logic [NUM_LOCKS-1:0] held_q;
  logic [LOCK_ID_BITS:0] locks_held_q, locks_held_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic ack_tvalid_q;
  logic [7:0] ack_tdata_q;
  logic [ACC_ID_BITS-1:0] ack_tdest_q;
  logic owner_ok, grant, release_ok, illegal;
  logic unused;
  assign unused = ^cmd_tdata[63:8+LOCK_ID_BITS];
`ifdef LOCK_OWNER_CHECK_EN
  logic [ACC_ID_BITS-1:0] owner_q [NUM_LOCKS];
  always_ff @(posedge clk)
    if (grant) owner_q[lid_q] <= aid_q;
  assign owner_ok = owner_q[lid_q] == aid_q;
`else
  assign owner_ok = 1'b1;
`endif
  always_comb begin
    grant = state_q == EXEC && code_q == 8'h04 && !held_q[lid_q];
    release_ok = state_q == EXEC && code_q == 8'h06 && held_q[lid_q] && owner_ok;
    illegal = state_q == EXEC && code_q != 8'h04 && !release_ok;
    err_cnt_d = (illegal && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
    locks_held_d = grant ? locks_held_q + (LOCK_ID_BITS+1)'(1) :
                   release_ok ? locks_held_q - (LOCK_ID_BITS+1)'(1) : locks_held_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q <= '0;
      lid_q <= '0;
      aid_q <= '0;
      held_q <= '0;
      locks_held_q <= '0;
      err_cnt_q <= '0;
      ack_tvalid_q <= 1'b0;
      ack_tdata_q <= '0;
      ack_tdest_q <= '0;
    end else begin
      locks_held_q <= locks_held_d;
      err_cnt_q <= err_cnt_d;
      if (grant) held_q[lid_q] <= 1'b1;
      if (release_ok) held_q[lid_q] <= 1'b0;
      case (state_q)
        IDLE: if (cmd_tvalid) begin
          code_q <= cmd_tdata[7:0];
          lid_q <= cmd_tdata[8 +: LOCK_ID_BITS];
          aid_q <= cmd_tid;
          state_q <= EXEC;
        end
        EXEC: begin
          ack_tvalid_q <= code_q == 8'h04;
          ack_tdata_q <= code_q == 8'h04 ? {7'b0, grant} : ack_tdata_q;
          ack_tdest_q <= code_q == 8'h04 ? aid_q : ack_tdest_q;
          state_q <= code_q == 8'h04 ? RESP : IDLE;
        end
        RESP: if (ack_tready) begin
          ack_tvalid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Gated by rst so the port reads 0 for the whole reset cycle and 1 as soon as rst drops.
  assign cmd_tready = state_q == IDLE && !rst;
  assign ack_tvalid = ack_tvalid_q;
  assign ack_tdata = ack_tdata_q;
  assign ack_tdest = ack_tdest_q;
  assign locks_held = locks_held_q;
  assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_lock_arbiter.sv
// tb_lock_arbiter: randomized and directed checks of lock_arbiter against a transaction-level lock table model.
module tb_lock_arbiter;
  localparam int NL = 256;
  localparam int AB = 8;
  localparam int LB = $clog2(NL);
  logic clk = 0, rst = 1, cmd_tvalid = 0, ack_tready = 1;
  logic [63:0] cmd_tdata = '0;
  logic [AB-1:0] cmd_tid = '0;
  logic cmd_tready, ack_tvalid;
  logic [7:0] ack_tdata;
  logic [AB-1:0] ack_tdest;
  logic [LB:0] locks_held;
  logic [15:0] err_cnt;
  lock_arbiter #(.NUM_LOCKS(NL), .ACC_ID_BITS(AB)) dut (
    .clk(clk), .rst(rst), .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
    .cmd_tdata(cmd_tdata), .cmd_tid(cmd_tid), .ack_tvalid(ack_tvalid),
    .ack_tready(ack_tready), .ack_tdata(ack_tdata), .ack_tdest(ack_tdest),
    .locks_held(locks_held), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  bit chk_en = 0, exp_tready = 0, exp_ack_v = 0;
  int exp_ack_d = 0, exp_ack_dest = 0;
  bit held_m [NL];
  int owner_m [NL];
  int cnt_m = 0, err_m = 0;
  logic [31:0] last_d, last_dest;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_tready", 32'(cmd_tready), 32'(exp_tready));
      chk("ack_tvalid", 32'(ack_tvalid), 32'(exp_ack_v));
      if (exp_ack_v) begin
        chk("ack_tdata", 32'(ack_tdata), 32'(exp_ack_d));
        chk("ack_tdest", 32'(ack_tdest), 32'(exp_ack_dest));
      end
      chk("locks_held", 32'(locks_held), 32'(cnt_m));
      chk("err_cnt", 32'(err_cnt), 32'(err_m));
    end
    if (ack_tvalid && ack_tready) begin
      last_d = 32'(ack_tdata);
      last_dest = 32'(ack_tdest);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input int cycles);
    chk_en = 0;
    rst = 1;
    cmd_tvalid = 0;
    ack_tready = 1;
    #1 chk("tready_in_reset", 32'(cmd_tready), 32'd0);
    repeat (cycles) step();
    foreach (held_m[i]) held_m[i] = 0;
    cnt_m = 0;
    err_m = 0;
    exp_tready = 0;
    exp_ack_v = 0;
    chk_en = 1;
    chk("ack_tdata_reset", 32'(ack_tdata), 32'd0);
    chk("ack_tdest_reset", 32'(ack_tdest), 32'd0);
    step();
    rst = 0;
    exp_tready = 1;
  endtask
  task automatic do_cmd(input logic [7:0] code, input int lid, input int tid, input int stall, input bit abort = 0);
    logic [63:0] d;
    int l;
    bit ok, rel;
    d = {$urandom, $urandom};
    d[7:0] = code;
    d[8 +: LB] = LB'(lid);
    l = int'((d >> 8) % NL);
    cmd_tdata = d;
    cmd_tid = AB'(tid);
    cmd_tvalid = 1;
    step();
    cmd_tvalid = 0;
    cmd_tdata = {$urandom, $urandom};
    cmd_tid = AB'($urandom);
    exp_tready = 0;
    exp_ack_v = 0;
    ok = !held_m[l];
`ifdef LOCK_OWNER_CHECK_EN
    rel = held_m[l] && owner_m[l] == tid;
`else
    rel = held_m[l];
`endif
    step();
    if (code == 8'h04) begin
      if (ok) begin
        held_m[l] = 1;
        owner_m[l] = tid;
        cnt_m++;
      end
      exp_ack_v = 1;
      exp_ack_d = int'(ok);
      exp_ack_dest = tid;
      if (abort) begin
        ack_tready = 0;
        step();
        do_reset(1);
        return;
      end
      ack_tready = stall == 0;
      repeat (stall) step();
      ack_tready = 1;
      step();
      exp_ack_v = 0;
    end else if (code == 8'h06 && rel) begin
      held_m[l] = 0;
      cnt_m--;
    end else if (err_m < 65535) err_m++;
    exp_tready = 1;
  endtask
  initial begin
    do_reset(2);
    chk("held_after_reset", 32'(locks_held), 32'd0);
    chk("err_after_reset", 32'(err_cnt), 32'd0);
    last_d = '1;
    do_cmd(8'h04, 5, 3, 0);
    chk("lock5_acc3_ack", last_d, 32'h01);
    chk("lock5_acc3_dest", last_dest, 32'd3);
    chk("lock5_held", 32'(locks_held), 32'd1);
    last_d = '1;
    do_cmd(8'h04, 5, 7, 0);
    chk("lock5_acc7_ack", last_d, 32'h00);
    chk("lock5_acc7_dest", last_dest, 32'd7);
    chk("lock5_acc7_held", 32'(locks_held), 32'd1);
    last_d = '1;
    do_cmd(8'h04, 5, 3, 0);
    chk("relock5_acc3_ack", last_d, 32'h00);
    do_cmd(8'h06, 5, 7, 0);
`ifdef LOCK_OWNER_CHECK_EN
    chk("unlock_acc7_err", 32'(err_cnt), 32'd1);
    chk("unlock_acc7_held", 32'(locks_held), 32'd1);
    do_cmd(8'h06, 5, 3, 0);
    chk("unlock_acc3_held", 32'(locks_held), 32'd0);
`else
    chk("unlock_acc7_err", 32'(err_cnt), 32'd0);
    chk("unlock_acc7_held", 32'(locks_held), 32'd0);
`endif
    last_d = '1;
    do_cmd(8'h04, 8, 2, 10);
    chk("stall_ack", last_d, 32'h01);
    do_cmd(8'h06, 8, 2, 0);
    chk("stall_release", 32'(locks_held), 32'd0);
    do_reset(1);
    do_cmd(8'h09, 3, 1, 0);
    do_cmd(8'h06, 255, 1, 0);
    chk("illegal_err2", 32'(err_cnt), 32'd2);
    force dut.err_cnt_q = 16'hFFFE;
    #1 release dut.err_cnt_q;
    err_m = 65534;
    step();
    do_cmd(8'h09, 0, 0, 0);
    chk("err_reach_max", 32'(err_cnt), 32'hFFFF);
    do_cmd(8'h06, 255, 0, 0);
    chk("err_saturate", 32'(err_cnt), 32'hFFFF);
    do_cmd(8'h04, 9, 2, 0, 1);
    chk("abort_held", 32'(locks_held), 32'd0);
    chk("abort_ack_low", 32'(ack_tvalid), 32'd0);
    last_d = '1;
    do_cmd(8'h04, 9, 4, 0);
    chk("regrant_after_abort", last_d, 32'h01);
    repeat (400) begin
      int r;
      logic [7:0] code;
      r = $urandom_range(0, 9);
      code = r < 4 ? 8'h04 : r < 8 ? 8'h06 : 8'($urandom);
      do_cmd(code, $urandom_range(0, 4) == 0 ? 255 : $urandom_range(0, 7), $urandom_range(0, 3),
             $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0, $urandom_range(0, 49) == 0);
      repeat ($urandom_range(0, 1)) step();
    end
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lock_arbiter.md
LOCK_ARBITER -- requirements
Module: lock_arbiter

Interface
REQ-001 SHALL have parameter NUM_LOCKS, default 256, number of independent locks (power of two, 2..256).
REQ-002 SHALL have parameter ACC_ID_BITS, default 8, width of accelerator identifier.
REQ-003 SHALL have derived localparam LOCK_ID_BITS = $clog2(NUM_LOCKS).
REQ-004 SHALL have clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have cmd_tvalid  input  1  command beat valid.
REQ-007 SHALL have cmd_tready  output  1  command beat accepted when high with cmd_tvalid.
REQ-008 SHALL have cmd_tdata  input  64  command word: [7:0] code, [8 +: LOCK_ID_BITS] lock ID.
REQ-009 SHALL have cmd_tid  input  ACC_ID_BITS  requesting accelerator ID.
REQ-010 SHALL have ack_tvalid  output  1  acknowledge valid.
REQ-011 SHALL have ack_tready  input  1  acknowledge consumed.
REQ-012 SHALL have ack_tdata  output  8  ack code: 0x01 OK, 0x00 REJECT.
REQ-013 SHALL have ack_tdest  output  ACC_ID_BITS  destination accelerator ID.
REQ-014 SHALL have locks_held  output  LOCK_ID_BITS+1  count of currently held locks.
REQ-015 SHALL have err_cnt  output  16  saturating count of illegal commands.

Function
REQ-016 SHALL implement FSM IDLE -> EXEC -> (RESP | IDLE); only one command in flight.
REQ-017 SHALL drive cmd_tready=1 only in IDLE; accepted beat registered into code/lock ID/acc ID, FSM -> EXEC.
REQ-018 SHALL in EXEC for code 0x04 (LOCK): free lock -> mark held, record owner=acc ID, ack 0x01; held lock (any owner, including requester) -> no change, ack 0x00; FSM -> RESP.
REQ-019 SHALL in EXEC for code 0x06 (UNLOCK): held lock with permitted owner -> mark free, FSM -> IDLE, no ack generated.
REQ-020 SHALL treat UNLOCK of a free lock, UNLOCK by a non-permitted owner, and any code other than 0x04/0x06 as illegal: table unchanged, err_cnt +1, no ack, FSM -> IDLE.
REQ-021 SHALL ignore cmd_tdata bits above the lock ID field and lock-ID bits beyond LOCK_ID_BITS.
REQ-022 SHALL in RESP hold ack_tvalid=1 with stable ack_tdata/ack_tdest until ack_tready=1; on that cycle FSM -> IDLE.
REQ-023 SHALL give LOCK latency: ack_tvalid asserted exactly 2 cycles after accept cycle (accept, EXEC, RESP).
REQ-024 SHALL sustain one command per 2 cycles (UNLOCK/illegal) or 3 cycles (LOCK with ack_tready tied high).
REQ-025 SHALL update locks_held in the same cycle as the table write (+1 on grant, -1 on release); never wrap.
REQ-026 SHALL saturate err_cnt at 0xFFFF.

Reset
REQ-027 SHALL on rst=1 force FSM to IDLE, all locks free, locks_held=0, err_cnt=0, ack_tvalid=0, ack_tdata=0, ack_tdest=0, cmd_tready=0 during reset cycle.
REQ-028 SHALL on reset mid-operation discard the in-flight command and any pending ack without emitting it.
REQ-029 SHALL assert cmd_tready=1 the first cycle after rst deasserts.

Configuration
REQ-030 SHALL honour macro LOCK_OWNER_CHECK_EN: defined -> owner ID stored per lock, UNLOCK permitted only when cmd_tid equals stored owner, else illegal.
REQ-031 SHALL when LOCK_OWNER_CHECK_EN undefined store no owner IDs; UNLOCK of any held lock permitted from any accelerator; UNLOCK of a free lock still illegal.

Verification
REQ-032 SHALL cover: reset, LOCK id 5 from acc 3 -> ack 0x01 dest 3 two cycles after accept, locks_held=1.
REQ-033 SHALL cover: after REQ-032, LOCK id 5 from acc 7 -> ack 0x00 dest 7, locks_held stays 1; LOCK id 5 from acc 3 -> ack 0x00.
REQ-034 SHALL cover: with LOCK_OWNER_CHECK_EN, UNLOCK id 5 from acc 7 -> no ack, err_cnt=1, lock still held; UNLOCK from acc 3 -> locks_held=0; without macro, UNLOCK from acc 7 -> released, err_cnt=0.
REQ-035 SHALL cover: ack_tready held low 10 cycles on a grant -> ack stable 10 cycles, cmd_tready=0 throughout, next command accepted cycle after handshake.
REQ-036 SHALL cover: code 0x09 and UNLOCK of free lock id 255 -> no ack, err_cnt=2; err_cnt preset path to 0xFFFF stays 0xFFFF.
REQ-037 SHALL cover: rst asserted while in RESP with ack_tready=0 -> ack_tvalid=0 next cycle, locks_held=0, previously held lock grantable.
